// File: rtl/keccak_squeeze.sv
`default_nettype none
// ============================================================================
// keccak_squeeze : SHA-3/SHAKE squeeze serializer. Emits rate lanes as 64-bit
//                  words and requests extra permutations for long digests.
// Rev 1.0 - initial release
// ============================================================================
module keccak_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4:0][4:0][63:0]  state_in,
    output logic                   busy,
    output logic                   perm_req,
    output logic [4:0][4:0][63:0]  perm_state_out,
    input  logic                   perm_ack,
    input  logic [4:0][4:0][63:0]  perm_state_in,
    output logic [63:0]            dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   done
);

    localparam int LW = $clog2(25);
    localparam int CW = $clog2(OUT_LANES + 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(RATE_LANES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OUT_LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_PERM = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [4:0][4:0][63:0]   held_q, held_d;
    logic [LW-1:0]           lane_idx_q, lane_idx_d;
    logic [CW-1:0]           out_cnt_q, out_cnt_d;
    logic [24:0][63:0]       lanes_w;

    // Flattening [y][x] gives lane index x + 5*y directly.
    assign lanes_w = held_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            held_q     <= '0;
            lane_idx_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            lane_idx_q <= lane_idx_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        lane_idx_d = lane_idx_q;
        out_cnt_d  = out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    held_d     = state_in;
                    lane_idx_d = '0;
                    out_cnt_d  = '0;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (dout_ready) begin
                    if (out_cnt_q == CNT_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                        if (lane_idx_q == LANE_LAST) begin
                            state_d = S_PERM;
                        end else begin
                            lane_idx_d = lane_idx_q + LW'(1);
                        end
                    end
                end
            end
            S_PERM: begin
                if (perm_ack) begin
                    held_d     = perm_state_in;
                    lane_idx_d = '0;
                    state_d    = S_EMIT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        busy           = (state_q != S_IDLE);
        perm_req       = (state_q == S_PERM);
        perm_state_out = held_q;
        dout_valid     = (state_q == S_EMIT);
        dout           = '0;
        dout_last      = 1'b0;
        done           = (state_q == S_FIN);
        if (state_q == S_EMIT) begin
            dout      = lanes_w[lane_idx_q];
            dout_last = (out_cnt_q == CNT_LAST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_squeeze.sv
`default_nettype none
// ============================================================================
// tb_keccak_squeeze : three squeeze instances (17/4, 21/25, 17/34) driven with
//                     random states and backpressure, checked against a model.
// Rev 1.0 - initial release
// ============================================================================
module tb_keccak_squeeze;

    typedef logic [4:0][4:0][63:0] st_t;
    localparam int NI = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start          [NI];
    st_t         state_in       [NI];
    logic        busy           [NI];
    logic        perm_req       [NI];
    st_t         perm_state_out [NI];
    logic        perm_ack       [NI];
    st_t         perm_state_in  [NI];
    logic [63:0] dout           [NI];
    logic        dout_valid     [NI];
    logic        dout_ready     [NI];
    logic        dout_last      [NI];
    logic        done           [NI];

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            keccak_squeeze #(
                .RATE_LANES ((k == 1) ? 21 : 17),
                .OUT_LANES  ((k == 0) ? 4 : ((k == 1) ? 25 : 34))
            ) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .start          (start[k]),
                .state_in       (state_in[k]),
                .busy           (busy[k]),
                .perm_req       (perm_req[k]),
                .perm_state_out (perm_state_out[k]),
                .perm_ack       (perm_ack[k]),
                .perm_state_in  (perm_state_in[k]),
                .dout           (dout[k]),
                .dout_valid     (dout_valid[k]),
                .dout_ready     (dout_ready[k]),
                .dout_last      (dout_last[k]),
                .done           (done[k])
            );
        end
    endgenerate

    // Reference model state per instance.
    logic [63:0] exp_w    [NI][64];
    st_t         exp_p    [NI][4];
    int          exp_n    [NI];
    int          pexp_n   [NI];
    int          got_n    [NI];
    int          perm_n   [NI];
    bit          job_done [NI];
    int          rmode    [NI];
    int          pdly     [NI];
    bit          noise    [NI];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rl_of(input int k);
        return (k == 1) ? 21 : 17;
    endfunction

    function automatic int ol_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 25 : 34);
    endfunction

    // Stand-in permutation: every lane plus 99.
    function automatic st_t perm_fn(input st_t s);
        st_t r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[y][x] = s[y][x] + 64'd99;
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[y][x] = {$urandom, $urandom};
        return r;
    endfunction

    // Word n comes from lane n mod rate of the block n / rate.
    task automatic build(input int k, input st_t s);
        st_t cur;
        int  rl, ol, li;
        cur = s;
        rl  = rl_of(k);
        ol  = ol_of(k);
        exp_n[k]    = ol;
        pexp_n[k]   = 0;
        got_n[k]    = 0;
        perm_n[k]   = 0;
        job_done[k] = 1'b0;
        for (int n = 0; n < ol; n++) begin
            if (n > 0 && (n % rl) == 0) begin
                exp_p[k][pexp_n[k]] = cur;
                pexp_n[k]++;
                cur = perm_fn(cur);
            end
            li = n % rl;
            exp_w[k][n] = cur[li / 5][li % 5];
        end
    endtask

    // Sink and permutation-core behaviour, driven on the falling edge.
    initial begin : env
        int pcnt [NI];
        int vcnt [NI];
        for (int k = 0; k < NI; k++) begin
            pcnt[k] = 0;
            vcnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!busy[k]) vcnt[k] = 0;
                case (rmode[k])
                    0: dout_ready[k] = 1'b1;
                    1: begin
                        dout_ready[k] = ((vcnt[k] % 3) == 0);
                        if (dout_valid[k]) vcnt[k]++;
                    end
                    default: dout_ready[k] = 1'($urandom_range(0, 1));
                endcase
                if (!rst_n) begin
                    perm_ack[k] = 1'b0;
                    pcnt[k]     = 0;
                end else if (perm_req[k]) begin
                    if (pcnt[k] == pdly[k]) begin
                        perm_ack[k]      = 1'b1;
                        perm_state_in[k] = perm_fn(perm_state_out[k]);
                    end else begin
                        perm_ack[k] = 1'b0;
                    end
                    pcnt[k]++;
                end else begin
                    pcnt[k]          = 0;
                    perm_ack[k]      = noise[k] && ($urandom_range(0, 3) == 0);
                    perm_state_in[k] = rand_state();
                end
            end
        end
    end

    // Output monitor against the model.
    initial begin : mon
        bit          hold_v [NI];
        logic [63:0] hold_d [NI];
        bit          last_p [NI];
        bit          preq_p [NI];
        for (int k = 0; k < NI; k++) begin
            hold_v[k] = 1'b0;
            hold_d[k] = '0;
            last_p[k] = 1'b0;
            preq_p[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    hold_v[k] = 1'b0;
                    last_p[k] = 1'b0;
                    preq_p[k] = 1'b0;
                end else begin
                    if (hold_v[k]) begin
                        check($sformatf("u%0d.stall_valid", k), 64'(dout_valid[k]), 64'd1);
                        check($sformatf("u%0d.stall_data", k), dout[k], hold_d[k]);
                    end
                    if (last_p[k]) begin
                        check($sformatf("u%0d.done", k), 64'(done[k]), 64'd1);
                        job_done[k] = 1'b1;
                    end else if (done[k]) begin
                        check($sformatf("u%0d.spurious_done", k), 64'(done[k]), 64'd0);
                    end
                    last_p[k] = 1'b0;
                    if (perm_req[k] && !preq_p[k]) begin
                        if (perm_n[k] < pexp_n[k])
                            check($sformatf("u%0d.perm_state%0d", k, perm_n[k]),
                                  64'(perm_state_out[k] == exp_p[k][perm_n[k]]), 64'd1);
                        else
                            check($sformatf("u%0d.perm_extra", k), 64'(perm_n[k] + 1), 64'(pexp_n[k]));
                        perm_n[k]++;
                    end
                    preq_p[k] = perm_req[k];
                    if (dout_valid[k] && dout_ready[k]) begin
                        if (got_n[k] < exp_n[k]) begin
                            check($sformatf("u%0d.word%0d", k, got_n[k]), dout[k], exp_w[k][got_n[k]]);
                            check($sformatf("u%0d.last%0d", k, got_n[k]), 64'(dout_last[k]),
                                  64'(got_n[k] == exp_n[k] - 1));
                            got_n[k]++;
                            last_p[k] = (got_n[k] == exp_n[k]);
                        end else begin
                            check($sformatf("u%0d.extra_word", k), 64'(got_n[k] + 1), 64'(exp_n[k]));
                        end
                    end
                    hold_v[k] = dout_valid[k] && !dout_ready[k];
                    hold_d[k] = dout[k];
                end
            end
        end
    end

    task automatic check_idle(input int k, input string tag);
        check($sformatf("u%0d.%s_busy", k, tag), 64'(busy[k]), 64'd0);
        check($sformatf("u%0d.%s_valid", k, tag), 64'(dout_valid[k]), 64'd0);
        check($sformatf("u%0d.%s_dout", k, tag), dout[k], 64'd0);
        check($sformatf("u%0d.%s_last", k, tag), 64'(dout_last[k]), 64'd0);
        check($sformatf("u%0d.%s_preq", k, tag), 64'(perm_req[k]), 64'd0);
        check($sformatf("u%0d.%s_done", k, tag), 64'(done[k]), 64'd0);
        check($sformatf("u%0d.%s_pstate", k, tag), 64'(perm_state_out[k] == '0), 64'd1);
    endtask

    task automatic launch(input int k, input st_t s);
        build(k, s);
        @(negedge clk);
        state_in[k] = s;
        start[k]    = 1'b1;
        @(negedge clk);
        start[k]    = 1'b0;
        state_in[k] = rand_state();
        #3;
        check($sformatf("u%0d.first_valid", k), 64'(dout_valid[k]), 64'd1);
        check($sformatf("u%0d.busy_run", k), 64'(busy[k]), 64'd1);
    endtask

    // Optionally fires stray starts (with a different state) while busy.
    task automatic wait_job(input int k, input bit stray);
        int cyc;
        cyc = 0;
        while (!job_done[k] && cyc < 3000) begin
            @(negedge clk);
            if (stray) begin
                start[k]    = busy[k] && ($urandom_range(0, 2) == 0);
                state_in[k] = rand_state();
            end
            cyc++;
        end
        start[k] = 1'b0;
        check($sformatf("u%0d.timeout", k), 64'(job_done[k]), 64'd1);
        @(negedge clk);
        #3;
        check($sformatf("u%0d.busy_after", k), 64'(busy[k]), 64'd0);
        check($sformatf("u%0d.word_count", k), 64'(got_n[k]), 64'(exp_n[k]));
        check($sformatf("u%0d.perm_count", k), 64'(perm_n[k]), 64'(pexp_n[k]));
    endtask

    task automatic run_job(input int k, input st_t s, input bit stray);
        launch(k, s);
        wait_job(k, stray);
    endtask

    initial begin : main
        st_t ds;
        int  k, cyc;
        for (int i = 0; i < NI; i++) begin
            start[i]    = 1'b0;
            state_in[i] = '0;
            rmode[i]    = 0;
            pdly[i]     = 3;
            noise[i]    = 1'b0;
            exp_n[i]    = 0;
            pexp_n[i]   = 0;
            got_n[i]    = 0;
            perm_n[i]   = 0;
            job_done[i] = 1'b0;
        end
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                ds[y][x] = 64'(5 * y + x + 1);

        repeat (3) @(negedge clk);
        #3;
        for (int i = 0; i < NI; i++) check_idle(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed jobs on each configuration.
        rmode[0] = 0; run_job(0, ds, 1'b0);
        rmode[0] = 1; run_job(0, ds, 1'b0);
        rmode[1] = 0; pdly[1] = 3; run_job(1, ds, 1'b0);
        rmode[2] = 0; pdly[2] = 3; run_job(2, ds, 1'b0);

        // Restart attempts while busy must not disturb the job.
        rmode[0] = 1; run_job(0, ds, 1'b1);
        rmode[1] = 2; run_job(1, ds, 1'b1);

        // Randomized jobs with stray acks and starts.
        for (int it = 0; it < 12; it++) begin
            k        = $urandom_range(0, NI - 1);
            rmode[k] = $urandom_range(0, 2);
            pdly[k]  = $urandom_range(0, 4);
            noise[k] = 1'b1;
            run_job(k, rand_state(), 1'(it % 2));
        end
        for (int i = 0; i < NI; i++) noise[i] = 1'b0;

        // Abort mid-job by reset after the second word is accepted.
        rmode[0] = 0;
        launch(0, ds);
        cyc = 0;
        while (got_n[0] < 2 && cyc < 100) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        check("u0.reach_word2", 64'(got_n[0]), 64'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) check_idle(i, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check_idle(0, "post_abort");
        run_job(0, rand_state(), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
